// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - architectural PC, N/Z/V flags, halt state and branch resolution
module pc_branch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [2:0]  FLAG_RESET = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [3:0]  opcode,
    input  logic        branch,
    input  logic        branch_reg,
    input  logic [2:0]  ccc,
    input  logic [8:0]  imm9,
    input  logic [15:0] rs_data,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_v,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        taken,
    output logic [2:0]  flags,
    output logic        halted
);

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [2:0]  flags_q, flags_d;

    logic        flag_n, flag_z, flag_v;
    logic        cond_true;
    logic [15:0] branch_off;
    logic [15:0] branch_target;

    assign flag_n = flags_q[2];
    assign flag_z = flags_q[1];
    assign flag_v = flags_q[0];

    // Word offset: sign-extend the 9-bit field and scale to bytes.
    assign branch_off    = {{6{imm9[8]}}, imm9, 1'b0};
    assign pc_plus2      = pc_q + 16'd2;
    assign branch_target = pc_plus2 + branch_off;

    // Branch condition, always judged on flags left by earlier instructions.
    always_comb begin
        cond_true = 1'b0;
        case (ccc)
            3'b000:  cond_true = ~flag_z;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = ~flag_z & ~flag_n;
            3'b011:  cond_true = flag_n;
            3'b100:  cond_true = flag_z | (~flag_z & ~flag_n);
            3'b101:  cond_true = flag_n | flag_z;
            3'b110:  cond_true = flag_v;
            default: cond_true = 1'b1;
        endcase
    end

    // A halted core never redirects, even with stall asserted.
    assign taken = branch & cond_true & (state_q == S_RUN);

    // Next-state, next-PC and flag-update selection; everything holds unless running and not stalled.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        if ((state_q == S_RUN) && !stall) begin
            if (taken && !branch_reg) begin
                pc_d = branch_target;
            end else if (taken && branch_reg) begin
                pc_d = rs_data;
            end else if (opcode == OP_HLT) begin
                pc_d = pc_q;
            end else begin
                pc_d = pc_plus2;
            end

            case (opcode)
                OP_ADD, OP_SUB:                 flags_d = {alu_n, alu_z, alu_v};
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d = {flag_n, alu_z, flag_v};
                default:                        flags_d = flags_q;
            endcase

            if (opcode == OP_HLT) begin
                state_d = S_HALTED;
            end
        end
    end

    // Architectural state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            flags_q <= FLAG_RESET;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

    assign pc     = pc_q;
    assign flags  = flags_q;
    assign halted = (state_q == S_HALTED);

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - self-checking bench for pc_branch_unit
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [3:0]  opcode;
    logic        branch;
    logic        branch_reg;
    logic [2:0]  ccc;
    logic [8:0]  imm9;
    logic [15:0] rs_data;
    logic        alu_n, alu_z, alu_v;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        taken;
    logic [2:0]  flags;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    // Reference state
    int          m_pc;
    logic [2:0]  m_flags;
    logic        m_halt;

    pc_branch_unit #(.RESET_PC(16'h0000), .FLAG_RESET(3'b000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .opcode(opcode),
        .branch(branch), .branch_reg(branch_reg), .ccc(ccc), .imm9(imm9),
        .rs_data(rs_data), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
        .pc(pc), .pc_plus2(pc_plus2), .taken(taken), .flags(flags),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        br;
        logic        brr;
        logic [2:0]  cc;
        logic [8:0]  imm;
        logic [15:0] rs;
        logic [2:0]  nzv;
        logic        stl;
        logic        e_taken;
        logic [15:0] e_pp;
        logic [15:0] e_pc;
        logic [2:0]  e_flags;
        logic        e_halt;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_cond(input logic [2:0] f, input logic [2:0] c);
        logic n, z, v;
        n = f[2]; z = f[1]; v = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic model_taken();
        return branch && model_cond(m_flags, ccc) && !m_halt;
    endfunction

    task automatic model_reset();
        m_pc = 0;
        m_flags = 3'b000;
        m_halt = 1'b0;
    endtask

    task automatic model_step();
        int off;
        if (m_halt || stall) return;
        off = $signed(imm9) * 2;
        if (model_taken()) begin
            if (branch_reg) m_pc = int'(rs_data);
            else            m_pc = (m_pc + 2 + off) & 16'hFFFF;
        end else if (opcode != 4'd15) begin
            m_pc = (m_pc + 2) % 65536;
        end
        if (opcode == 4'd0 || opcode == 4'd1)
            m_flags = {alu_n, alu_z, alu_v};
        else if (opcode == 4'd2 || opcode == 4'd4 || opcode == 4'd5 || opcode == 4'd6)
            m_flags[1] = alu_z;
        if (opcode == 4'd15) m_halt = 1'b1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic [3:0] op, input logic br, input logic brr,
                          input logic [2:0] cc, input logic [8:0] im, input logic [15:0] rs,
                          input logic [2:0] nzv, input logic stl);
        opcode = op; branch = br; branch_reg = brr; ccc = cc; imm9 = im;
        rs_data = rs; {alu_n, alu_z, alu_v} = nzv; stall = stl;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic check_regs(input string tag, input logic [15:0] e_pc,
                              input logic [2:0] e_fl, input logic e_h);
        chk({tag, "_pc"}, pc, e_pc);
        chk({tag, "_flags"}, {13'd0, flags}, {13'd0, e_fl});
        chk({tag, "_halted"}, {15'd0, halted}, {15'd0, e_h});
    endtask

    initial begin
        set_in(4'b0011, 0, 0, 3'd0, 9'd0, 16'd0, 3'b000, 0);
        do_reset();
        check_regs("reset", 16'h0000, 3'b000, 1'b0);

        // op br brr ccc imm rs nzv stall | taken pp -> pc flags halt
        for (int i = 0; i < 4; i++)
            vq.push_back('{4'b0011, 0, 0, 3'd0, 9'h000, 16'h0000, 3'b000, 0, 0,
                           16'(2*i+2), 16'(2*i+2), 3'b000, 0});
        vq.push_back('{4'b1100, 1, 1, 3'd7, 9'h000, 16'h000E, 3'b000, 0, 1, 16'h000A, 16'h000E, 3'b000, 0});
        vq.push_back('{4'b0001, 0, 0, 3'd0, 9'h000, 16'h0000, 3'b010, 0, 0, 16'h0010, 16'h0010, 3'b010, 0});
        vq.push_back('{4'b1101, 1, 0, 3'd1, 9'h1FE, 16'h0000, 3'b000, 0, 1, 16'h0012, 16'h000E, 3'b010, 0});
        vq.push_back('{4'b0011, 0, 0, 3'd0, 9'h000, 16'h0000, 3'b000, 0, 0, 16'h0010, 16'h0010, 3'b010, 0});
        vq.push_back('{4'b1101, 1, 0, 3'd0, 9'h1FE, 16'h0000, 3'b000, 0, 0, 16'h0012, 16'h0012, 3'b010, 0});
        vq.push_back('{4'b1100, 1, 1, 3'd7, 9'h000, 16'h1234, 3'b000, 0, 1, 16'h0014, 16'h1234, 3'b010, 0});
        vq.push_back('{4'b1100, 1, 1, 3'd7, 9'h000, 16'h0040, 3'b000, 0, 1, 16'h1236, 16'h0040, 3'b010, 0});
        vq.push_back('{4'b1010, 0, 0, 3'd0, 9'h000, 16'h0000, 3'b000, 0, 0, 16'h0042, 16'h0042, 3'b010, 0});
        vq.push_back('{4'b0000, 0, 0, 3'd0, 9'h000, 16'h0000, 3'b000, 0, 0, 16'h0044, 16'h0044, 3'b000, 0});
        vq.push_back('{4'b0010, 0, 0, 3'd0, 9'h000, 16'h0000, 3'b111, 0, 0, 16'h0046, 16'h0046, 3'b010, 0});
        vq.push_back('{4'b0000, 0, 0, 3'd0, 9'h000, 16'h0000, 3'b111, 0, 0, 16'h0048, 16'h0048, 3'b111, 0});
        vq.push_back('{4'b1101, 1, 0, 3'd2, 9'h004, 16'h0000, 3'b000, 0, 0, 16'h004A, 16'h004A, 3'b111, 0});
        vq.push_back('{4'b1101, 1, 0, 3'd5, 9'h004, 16'h0000, 3'b000, 0, 1, 16'h004C, 16'h0054, 3'b111, 0});
        vq.push_back('{4'b1101, 1, 0, 3'd6, 9'h000, 16'h0000, 3'b000, 0, 1, 16'h0056, 16'h0056, 3'b111, 0});
        vq.push_back('{4'b0000, 0, 0, 3'd0, 9'h000, 16'h0000, 3'b000, 1, 0, 16'h0058, 16'h0056, 3'b111, 0});
        vq.push_back('{4'b1101, 1, 0, 3'd3, 9'h1FF, 16'h0000, 3'b000, 0, 1, 16'h0058, 16'h0056, 3'b111, 0});
        vq.push_back('{4'b0100, 0, 0, 3'd0, 9'h000, 16'h0000, 3'b000, 0, 0, 16'h0058, 16'h0058, 3'b101, 0});
        vq.push_back('{4'b1101, 1, 0, 3'd4, 9'h004, 16'h0000, 3'b000, 0, 0, 16'h005A, 16'h005A, 3'b101, 0});
        vq.push_back('{4'b1101, 1, 0, 3'd0, 9'h010, 16'h0000, 3'b000, 0, 1, 16'h005C, 16'h007C, 3'b101, 0});

        foreach (vq[i]) begin
            set_in(vq[i].op, vq[i].br, vq[i].brr, vq[i].cc, vq[i].imm, vq[i].rs, vq[i].nzv, vq[i].stl);
            @(negedge clk);
            chk($sformatf("vec%0d_taken", i), {15'd0, taken}, {15'd0, vq[i].e_taken});
            chk($sformatf("vec%0d_pc_plus2", i), pc_plus2, vq[i].e_pp);
            edge_step();
            check_regs($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_flags, vq[i].e_halt);
        end

        // HLT at 0x0020, branches ignored, async reset recovers
        set_in(4'b1100, 1, 1, 3'd7, 9'h000, 16'h0020, 3'b000, 0);
        edge_step();
        set_in(4'b1111, 0, 0, 3'd0, 9'h000, 16'h0000, 3'b000, 0);
        edge_step();
        check_regs("hlt", 16'h0020, 3'b101, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_in(4'b1100, 1, 1, 3'd7, 9'h000, 16'h5554, 3'b111, 0);
            @(negedge clk);
            chk($sformatf("halt%0d_taken", i), {15'd0, taken}, 16'd0);
            edge_step();
            check_regs($sformatf("halt%0d", i), 16'h0020, 3'b101, 1'b1);
        end
        #2 rst = 1'b1;
        #1 check_regs("async_rst", 16'h0000, 3'b000, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Stall during ADD, HLT and a taken branch
        set_in(4'b0011, 0, 0, 3'd0, 9'h000, 16'h0000, 3'b000, 0);
        edge_step();
        for (int i = 0; i < 3; i++) begin
            set_in(4'b0000, 0, 0, 3'd0, 9'h000, 16'h0000, 3'b111, 1);
            edge_step();
            check_regs($sformatf("stall_add%0d", i), 16'h0002, 3'b000, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            set_in(4'b1111, 0, 0, 3'd0, 9'h000, 16'h0000, 3'b000, 1);
            edge_step();
            check_regs($sformatf("stall_hlt%0d", i), 16'h0002, 3'b000, 1'b0);
        end
        set_in(4'b1100, 1, 1, 3'd7, 9'h000, 16'h4444, 3'b000, 1);
        @(negedge clk);
        chk("stall_taken", {15'd0, taken}, 16'd1);
        edge_step();
        check_regs("stall_br", 16'h0002, 3'b000, 1'b0);
        #2 rst = 1'b1;
        #1 check_regs("stall_rst", 16'h0000, 3'b000, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Wrap at 0xFFFE
        set_in(4'b1100, 1, 1, 3'd7, 9'h000, 16'hFFFE, 3'b000, 0);
        edge_step();
        set_in(4'b0011, 0, 0, 3'd0, 9'h000, 16'h0000, 3'b000, 0);
        @(negedge clk);
        chk("wrap_pc_plus2", pc_plus2, 16'h0000);
        edge_step();
        check_regs("wrap", 16'h0000, 3'b000, 1'b0);

        // Randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end
            op = 4'($urandom_range(0, 15));
            if (op == 4'd15 && $urandom_range(0, 3) != 0) op = 4'd3;
            set_in(op, 1'b0, 1'($urandom), 3'($urandom), 9'($urandom), 16'($urandom),
                   3'($urandom), ($urandom_range(0, 5) == 0));
            if (op == 4'd12 || op == 4'd13) branch = 1'($urandom);
            @(negedge clk);
            chk("rnd_taken", {15'd0, taken}, {15'd0, model_taken()});
            chk("rnd_pc_plus2", pc_plus2, 16'((m_pc + 2) % 65536));
            edge_step();
            check_regs("rnd", 16'(m_pc), m_flags, m_halt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
